apb_reg_bank: RTL and testbench

APB v2.0 completer holding `NoRegs` 32-bit software registers, with a programmable number of wait states and a fixed error response. It sits directly downstream of any APB requester or demux in the peripheral subsystem and consumes the shared APB protection type and response encodings: `RESP_OKAY` = 0 and `RESP_SLVERR` = 1 on `pslverr_o`. Register contents drive fabric-side outputs; read-only slots reflect fabric-side inputs.

---
 rtl/apb_reg_bank.sv | 110 +++++++++++
 tb/tb_apb_reg_bank.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/apb_reg_bank.sv
// rtl/apb_reg_bank.sv - APB completer with NoRegs 32-bit registers, programmable wait states and fixed error response.
// Optional privilege check enabled by defining APB_REG_BANK_PROT_CHECK_EN.
module apb_reg_bank #(
  parameter int                 NoRegs     = 4,
  parameter int                 AddrWidth  = 32,
  parameter int                 BaseAddr   = 0,
  parameter int                 WaitCycles = 0,
  parameter logic [NoRegs-1:0]  ReadOnly   = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [AddrWidth-1:0]   paddr_i,
  input  logic [2:0]             pprot_i,
  input  logic                   psel_i,
  input  logic                   penable_i,
  input  logic                   pwrite_i,
  input  logic [31:0]            pwdata_i,
  input  logic [3:0]             pstrb_i,
  output logic [31:0]            prdata_o,
  output logic                   pready_o,
  output logic                   pslverr_o,
  output logic [NoRegs*32-1:0]   reg_q_o,
  input  logic [NoRegs*32-1:0]   reg_d_i
);

  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;
  localparam int   CntW        = (WaitCycles > 0) ? $clog2(WaitCycles + 1) : 1;
  localparam int   IdxW        = (NoRegs > 1) ? $clog2(NoRegs) : 1;
  localparam logic [AddrWidth-1:0] BaseAddrW = AddrWidth'(BaseAddr);

  logic [CntW-1:0]        r_cnt_q;
  logic [31:0]            r_regs [NoRegs];

  logic                   w_access;
  logic [AddrWidth-1:0]   w_offset;
  logic [AddrWidth-3:0]   w_word;
  logic [IdxW-1:0]        w_idx;
  logic                   w_in_range;
  logic                   w_ro;
  logic                   w_prot_err;
  logic                   w_err;
  logic                   w_we;
  logic [31:0]            w_rdata;
  logic                   w_unused;

  assign w_access   = psel_i & penable_i;
  assign pready_o   = w_access & (r_cnt_q == CntW'(WaitCycles));

  assign w_offset   = paddr_i - BaseAddrW;
  assign w_word     = w_offset[AddrWidth-1:2];
  assign w_idx      = w_word[IdxW-1:0];
  assign w_in_range = (paddr_i >= BaseAddrW) && (w_word < (AddrWidth-2)'(NoRegs));
  assign w_unused   = ^{pprot_i, w_offset[1:0]};

`ifdef APB_REG_BANK_PROT_CHECK_EN
  assign w_prot_err = ~pprot_i[0];
`else
  assign w_prot_err = 1'b0;
`endif

  // Read mux also resolves the read-only flag of the addressed slot.
  always_comb begin
    w_rdata = '0;
    w_ro    = 1'b0;
    for (int i = 0; i < NoRegs; i++) begin
      if (w_idx == IdxW'(i)) begin
        w_ro    = ReadOnly[i];
        w_rdata = ReadOnly[i] ? reg_d_i[i*32 +: 32] : r_regs[i];
      end
    end
  end

  assign w_err     = ~w_in_range | (pwrite_i & w_ro) | w_prot_err;
  assign w_we      = pready_o & pwrite_i & ~w_err;
  assign pslverr_o = pready_o ? (w_err ? RESP_SLVERR : RESP_OKAY) : RESP_OKAY;
  assign prdata_o  = (pready_o & ~pwrite_i & ~w_err) ? w_rdata : 32'h0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt_q <= '0;
    end else if (!psel_i || pready_o) begin
      r_cnt_q <= '0;
    end else if (w_access) begin
      r_cnt_q <= r_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NoRegs; i++) r_regs[i] <= '0;
    end else if (w_we) begin
      for (int i = 0; i < NoRegs; i++) begin
        if (w_idx == IdxW'(i)) begin
          for (int b = 0; b < 4; b++) begin
            if (pstrb_i[b]) r_regs[i][8*b +: 8] <= pwdata_i[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    reg_q_o = '0;
    for (int i = 0; i < NoRegs; i++) begin
      reg_q_o[i*32 +: 32] = ReadOnly[i] ? 32'h0 : r_regs[i];
    end
  end

endmodule

// File: tb/tb_apb_reg_bank.sv
// tb/tb_apb_reg_bank.sv - scoreboard bench for apb_reg_bank (4 regs, 2 wait states, slot 2 read-only).
module tb_apb_reg_bank;

  localparam int          N_REGS = 4;
  localparam int          WAITS  = 2;
  localparam logic [3:0]  RO     = 4'b0100;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [31:0]   paddr_i = '0;
  logic [2:0]    pprot_i = '0;
  logic          psel_i = 1'b0;
  logic          penable_i = 1'b0;
  logic          pwrite_i = 1'b0;
  logic [31:0]   pwdata_i = '0;
  logic [3:0]    pstrb_i = '0;
  logic [31:0]   prdata_o;
  logic          pready_o;
  logic          pslverr_o;
  logic [127:0]  reg_q_o;
  logic [127:0]  reg_d_i;

  apb_reg_bank #(
    .NoRegs(N_REGS), .AddrWidth(32), .BaseAddr(0), .WaitCycles(WAITS), .ReadOnly(RO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .paddr_i(paddr_i), .pprot_i(pprot_i),
    .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i),
    .pwdata_i(pwdata_i), .pstrb_i(pstrb_i), .prdata_o(prdata_o),
    .pready_o(pready_o), .pslverr_o(pslverr_o), .reg_q_o(reg_q_o), .reg_d_i(reg_d_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic         err;
    logic [31:0]  rdata;
    int           waits;
    logic [127:0] regq;
  } exp_t;

  exp_t         sb_q[$];
  logic [31:0]  model [N_REGS];
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] model_q();
    logic [127:0] v = '0;
    for (int i = 0; i < N_REGS; i++) if (!RO[i]) v[i*32 +: 32] = model[i];
    return v;
  endfunction

  // Reference behaviour: decide the response from the address map, then apply the write.
  function automatic exp_t predict(input logic wr, input logic [31:0] addr,
                                   input logic [31:0] data, input logic [3:0] strb,
                                   input logic [2:0] prot);
    exp_t e;
    int unsigned idx = addr / 4;
    logic bad = (idx >= N_REGS);
    if (!bad && wr && RO[idx]) bad = 1'b1;
`ifdef APB_REG_BANK_PROT_CHECK_EN
    if (!prot[0]) bad = 1'b1;
`else
    if (prot == 3'b111) bad = bad;
`endif
    e.err   = bad;
    e.rdata = 32'h0;
    if (!bad && !wr) e.rdata = RO[idx] ? reg_d_i[idx*32 +: 32] : model[idx];
    if (!bad && wr) begin
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
    end
    e.waits = WAITS;
    e.regq  = model_q();
    return e;
  endfunction

  task automatic setup(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input logic [2:0] prot);
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr; paddr_i = addr;
    pwdata_i = data; pstrb_i = strb; pprot_i = prot;
    @(posedge clk_i); #1;
    penable_i = 1'b1;
  endtask

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [2:0] prot);
    sb_q.push_back(predict(wr, addr, data, strb, prot));
    setup(wr, addr, data, strb, prot);
    for (int n = 0; ; n++) begin
      @(negedge clk_i);
      if (pready_o) break;
      if (n > 20) begin
        check("pready_timeout", 1'b0, 1'b1);
        break;
      end
    end
    @(posedge clk_i); #1;
    psel_i = 1'b0; penable_i = 1'b0;
  endtask

  task automatic abort_write(input logic [31:0] addr, input logic [31:0] data);
    setup(1'b1, addr, data, 4'hF, 3'b001);
    @(posedge clk_i); #1;
    psel_i = 1'b0; penable_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  // Monitor: counts wait cycles, pops the scoreboard on completion, checks reg_q_o one cycle later.
  initial begin
    int   waits = 0;
    logic chk_q = 1'b0;
    exp_t cur;
    forever begin
      @(negedge clk_i);
      if (chk_q) begin
        check("reg_q_after", reg_q_o, cur.regq);
        chk_q = 1'b0;
      end
      if (!rst_ni || !psel_i) begin
        waits = 0;
      end else if (psel_i && penable_i) begin
        if (pready_o) begin
          if (sb_q.size() == 0) begin
            check("unexpected_ready", 1'b1, 1'b0);
          end else begin
            cur = sb_q.pop_front();
            check("wait_states", waits, cur.waits);
            check("pslverr", pslverr_o, cur.err);
            check("prdata", prdata_o, cur.rdata);
            chk_q = 1'b1;
          end
          waits = 0;
        end else begin
          check("idle_resp", {pslverr_o, prdata_o}, 33'h0);
          waits++;
        end
      end
    end
  end

  initial begin
    logic [31:0] a, d;
    logic        wr;
    reg_d_i = {32'h0BAD_F00D, 32'hCAFE_0000, 32'h1357_9BDF, 32'h2468_ACE0};
    for (int i = 0; i < N_REGS; i++) model[i] = '0;

    repeat (3) @(negedge clk_i);
    check("reset_outputs", {pready_o, pslverr_o, prdata_o}, 34'h0);
    check("reset_regq", reg_q_o, 128'h0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    check("idle_outputs", {pready_o, pslverr_o, prdata_o}, 34'h0);
    check("idle_regq", reg_q_o, 128'h0);
    @(posedge clk_i); #1;

    xfer(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 3'b001);
    xfer(1'b0, 32'h4, 32'h0, 4'h0, 3'b001);
    xfer(1'b1, 32'h4, 32'h11223344, 4'b0101, 3'b001);
    xfer(1'b0, 32'h4, 32'h0, 4'h0, 3'b001);
    xfer(1'b0, 32'h10, 32'h0, 4'h0, 3'b001);
    xfer(1'b1, 32'h8, 32'hFFFFFFFF, 4'hF, 3'b001);
    xfer(1'b0, 32'h8, 32'h0, 4'h0, 3'b001);
    xfer(1'b1, 32'hC, 32'h55AA55AA, 4'h0, 3'b001);
    abort_write(32'h0, 32'h1);
    xfer(1'b0, 32'h0, 32'h0, 4'h0, 3'b001);
    xfer(1'b1, 32'hC, 32'hA5A5A5A5, 4'hF, 3'b000);
    xfer(1'b1, 32'hC, 32'hA5A5A5A5, 4'hF, 3'b001);
    xfer(1'b0, 32'hC, 32'h0, 4'h0, 3'b001);

    for (int t = 0; t < 80; t++) begin
      wr = 1'($urandom);
      a  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 23));
      d  = $urandom;
      xfer(wr, a, d, 4'($urandom), 3'($urandom));
    end

    for (int n = 0; n < 50 && sb_q.size() != 0; n++) @(negedge clk_i);
    if (sb_q.size() != 0) check("scoreboard_drain", sb_q.size(), 0);
    repeat (2) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
